// File: rtl/decap_host_if_if.sv
// decap_host_if_if: signal bundle between the host stream, decap_host_if and the decap core.
// Parameters: RAMWIDTH (load word width), LOG_RAMDEPTH (core address width).
// Host side: ct_din/ct_din_valid/ct_din_ready in, ss_dout/ss_dout_valid/ss_dout_ready out,
//   busy, done, cycle_count.
// Core side: decap_in_type/decap_in/decap_in_addr/decap_in_wen, start, core_done,
//   decap_out_en/decap_out_addr/decap_out.
// slave is the decap_host_if view; master is the host/core-model view.
interface decap_host_if_if #(
   parameter int RAMWIDTH     = 128,
   parameter int LOG_RAMDEPTH = 8
);
   logic [31:0]             ct_din;
   logic                    ct_din_valid;
   logic                    ct_din_ready;
   logic [31:0]             ss_dout;
   logic                    ss_dout_valid;
   logic                    ss_dout_ready;
   logic                    busy;
   logic                    done;
   logic [1:0]              decap_in_type;
   logic [RAMWIDTH-1:0]     decap_in;
   logic [LOG_RAMDEPTH-1:0] decap_in_addr;
   logic                    decap_in_wen;
   logic                    start;
   logic                    core_done;
   logic                    decap_out_en;
   logic [LOG_RAMDEPTH-1:0] decap_out_addr;
   logic [31:0]             decap_out;
   logic [31:0]             cycle_count;
   modport slave (
      input  ct_din, ct_din_valid, ss_dout_ready, core_done, decap_out,
      output ct_din_ready, ss_dout, ss_dout_valid, busy, done, decap_in_type, decap_in,
             decap_in_addr, decap_in_wen, start, decap_out_en, decap_out_addr, cycle_count
   );
   modport master (
      output ct_din, ct_din_valid, ss_dout_ready, core_done, decap_out,
      input  ct_din_ready, ss_dout, ss_dout_valid, busy, done, decap_in_type, decap_in,
             decap_in_addr, decap_in_wen, start, decap_out_en, decap_out_addr, cycle_count
   );
endinterface

// File: rtl/decap_host_if.sv
// decap_host_if: loads a 32-bit ciphertext stream (u, v, d) into the decap core, starts it,
// then reads back the 16-word shared secret byte-reversed over valid/ready.
// Parameters: parameter_set ("hqc128"/"hqc192"/"hqc256") selects N; RAMWIDTH is the load word width.
// Ports: clk; rst (asynchronous, active-high); bus (decap_host_if_if.slave) carrying the host
//   stream (ct_din*, ss_dout*, busy, done, cycle_count) and the core load/read signals.
// Optional: define DECAP_HOST_CYCLE_CNT_EN to make cycle_count count WAIT_DONE cycles
//   (cleared at start, includes the cycle core_done is seen); otherwise cycle_count is 0.
module decap_host_if #(
   parameter logic [47:0] parameter_set = "hqc128",
   parameter int          RAMWIDTH      = 128
) (
   input logic            clk,
   input logic            rst,
   decap_host_if_if.slave bus
);
   localparam int N            = parameter_set == "hqc256" ? 57637 :
                                 parameter_set == "hqc192" ? 35851 : 17669;
   localparam int RAMDEPTH     = (N + RAMWIDTH - 1) / RAMWIDTH;
   localparam int LOG_RAMDEPTH = $clog2(RAMDEPTH);
   localparam int SS_WORDS     = 16;
   localparam int WPG          = RAMWIDTH / 32;
   localparam int LW           = $clog2(WPG + 1);
   localparam int CW           = $clog2(SS_WORDS + 1);

   typedef enum logic [2:0] {IDLE, LOAD_U, LOAD_V, LOAD_D, START, WAIT_DONE, READ_SS} state_t;

   state_t                  state_q;
   logic [LW-1:0]           lane_q;
   logic [LOG_RAMDEPTH-1:0] addr_q, raddr_q;
   logic [RAMWIDTH-1:0]     buf_q;
   logic [1:0]              type_q;
   logic                    wen_q, ready_q, start_q, busy_q, done_q, en_q, pend_q, ssv_q;
   logic [CW-1:0]           rcnt_q, acnt_q;
   logic [31:0]             ss_q;
   logic                    hs, ss_fire, last_lane;

   assign hs        = ready_q && bus.ct_din_valid;
   assign ss_fire   = ssv_q && bus.ss_dout_ready;
   assign last_lane = lane_q == LW'(WPG - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= '0;
         addr_q  <= '0;
         raddr_q <= '0;
         buf_q   <= '0;
         type_q  <= '0;
         wen_q   <= 1'b0;
         ready_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         pend_q  <= 1'b0;
         ssv_q   <= 1'b0;
         rcnt_q  <= '0;
         acnt_q  <= '0;
         ss_q    <= '0;
      end else begin
         wen_q   <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         pend_q  <= en_q;
         // a read is only issued when the output register will be free, so the capture never collides with a held word
         if (pend_q) begin
            ss_q  <= {bus.decap_out[7:0], bus.decap_out[15:8], bus.decap_out[23:16], bus.decap_out[31:24]};
            ssv_q <= 1'b1;
         end else if (ss_fire) begin
            ssv_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (hs) begin
                  state_q <= LOAD_U;
                  type_q  <= 2'd3;
                  busy_q  <= 1'b1;
               end
            end
            LOAD_U: begin
               if (wen_q) begin
                  ready_q <= 1'b1;
                  addr_q  <= addr_q == LOG_RAMDEPTH'(RAMDEPTH - 1) ? '0 : addr_q + 1'b1;
                  if (addr_q == LOG_RAMDEPTH'(RAMDEPTH - 1)) begin
                     state_q <= LOAD_V;
                     type_q  <= 2'd2;
                  end
               end
            end
            LOAD_V: begin
               if (wen_q) begin
                  ready_q <= 1'b1;
                  addr_q  <= addr_q == LOG_RAMDEPTH'(RAMDEPTH - 2) ? '0 : addr_q + 1'b1;
                  if (addr_q == LOG_RAMDEPTH'(RAMDEPTH - 2)) begin
                     state_q <= LOAD_D;
                     type_q  <= 2'd1;
                  end
               end
            end
            LOAD_D: begin
               if (wen_q) begin
                  if (addr_q == LOG_RAMDEPTH'(SS_WORDS - 1)) begin
                     addr_q  <= '0;
                     state_q <= START;
                     start_q <= 1'b1;
                     type_q  <= 2'd0;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     ready_q <= 1'b1;
                  end
               end else if (hs) begin
                  buf_q   <= RAMWIDTH'(bus.ct_din);
                  wen_q   <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            START: state_q <= WAIT_DONE;
            WAIT_DONE: if (bus.core_done) state_q <= READ_SS;
            READ_SS: begin
               if (!en_q && !pend_q && (!ssv_q || ss_fire) && rcnt_q != CW'(SS_WORDS)) begin
                  en_q    <= 1'b1;
                  raddr_q <= LOG_RAMDEPTH'(rcnt_q);
                  rcnt_q  <= rcnt_q + 1'b1;
               end
               if (ss_fire) begin
                  acnt_q <= acnt_q + 1'b1;
                  if (acnt_q == CW'(SS_WORDS - 1)) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                     rcnt_q  <= '0;
                     acnt_q  <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         // u/v packing: the last lane of a group turns into a one-cycle write with ready dropped
         if (hs && state_q != LOAD_D) begin
            buf_q[{lane_q, 5'd0} +: 32] <= bus.ct_din;
            lane_q  <= last_lane ? '0 : lane_q + 1'b1;
            wen_q   <= last_lane;
            ready_q <= !last_lane;
         end
      end
   end

`ifdef DECAP_HOST_CYCLE_CNT_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else if (state_q == START) cnt_q <= '0;
      else if (state_q == WAIT_DONE) cnt_q <= cnt_q + 1'b1;
   end
   assign bus.cycle_count = cnt_q;
`else
   assign bus.cycle_count = '0;
`endif

   assign bus.ct_din_ready   = ready_q;
   assign bus.ss_dout        = ss_q;
   assign bus.ss_dout_valid  = ssv_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.decap_in_type  = type_q;
   assign bus.decap_in       = buf_q;
   assign bus.decap_in_addr  = addr_q;
   assign bus.decap_in_wen   = wen_q;
   assign bus.start          = start_q;
   assign bus.decap_out_en   = en_q;
   assign bus.decap_out_addr = raddr_q;
endmodule

// File: tb/tb_decap_host_if.sv
// tb_decap_host_if: directed bench for decap_host_if (hqc128, RAMWIDTH 128) with a core model.
module tb_decap_host_if;
   localparam int NW = 1124;
`ifdef DECAP_HOST_CYCLE_CNT_EN
   localparam logic [31:0] CC = 32'd1000, CC_MID = 32'd499;
`else
   localparam logic [31:0] CC = 32'd0, CC_MID = 32'd0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, passed = 0, total = 0;
   int u_cnt, v_cnt, d_cnt, addr_err, data_err, start_cnt, done_cnt, stab_err, to_err;
   int start_cyc = 0;
   logic [127:0] first_u;
   logic [31:0] mem [16];
   logic [31:0] rx_q [$];
   logic prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   bit stalled;

   decap_host_if_if #(.RAMWIDTH(128), .LOG_RAMDEPTH(8)) bus ();
   decap_host_if #(.parameter_set("hqc128"), .RAMWIDTH(128)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.decap_out_en) bus.decap_out <= mem[bus.decap_out_addr[3:0]];

   function automatic logic [127:0] grp(input int b);
      logic [127:0] r;
      for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'(b + j);
      return r;
   endfunction

   function automatic logic [31:0] rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (bus.decap_in_wen) begin
         case (bus.decap_in_type)
            2'd3: begin
               if (bus.decap_in_addr !== 8'(u_cnt)) addr_err++;
               if (bus.decap_in !== grp(1 + 4 * u_cnt)) data_err++;
               if (u_cnt == 0) first_u = bus.decap_in;
               u_cnt++;
            end
            2'd2: begin
               if (bus.decap_in_addr !== 8'(v_cnt)) addr_err++;
               if (bus.decap_in !== grp(557 + 4 * v_cnt)) data_err++;
               v_cnt++;
            end
            2'd1: begin
               if (bus.decap_in_addr !== 8'(d_cnt)) addr_err++;
               if (bus.decap_in !== {96'd0, 32'(1109 + d_cnt)}) data_err++;
               d_cnt++;
            end
            default: addr_err++;
         endcase
      end
      if (bus.start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (bus.done) done_cnt++;
      if (prev_stall && (!bus.ss_dout_valid || bus.ss_dout !== prev_data)) stab_err++;
      if (bus.ss_dout_valid && bus.ss_dout_ready) rx_q.push_back(bus.ss_dout);
      prev_stall = bus.ss_dout_valid && !bus.ss_dout_ready;
      prev_data  = bus.ss_dout;
   end

   task automatic send(input logic [31:0] w);
      int t = 0;
      bus.ct_din = w;
      bus.ct_din_valid = 1'b1;
      while (!bus.ct_din_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) to_err++;
      @(negedge clk);
      bus.ct_din_valid = 1'b0;
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) send(32'(i + 1));
   endtask

   task automatic core();
      int t = 0;
      while (start_cnt == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      while (cyc < start_cyc + 500 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("cc_counting", bus.cycle_count, CC_MID);
      while (cyc < start_cyc + 1000 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) to_err++;
      bus.core_done = 1'b1;
      @(negedge clk);
      bus.core_done = 1'b0;
      chk("busy_wait", bus.busy, 1);
   endtask

   task automatic read_ss(input bit stall_mode);
      int t = 0, left = 0;
      stalled = 0;
      rx_q.delete();
      while (done_cnt == 0 && t < 600) begin
         @(posedge clk);
         #1;
         t++;
         if (stall_mode) begin
            if (!stalled && rx_q.size() == 5 && bus.ss_dout_valid) begin
               stalled = 1;
               left = 10;
            end
            bus.ss_dout_ready = (left > 0) ? 1'b0 : cyc[0];
            if (left > 0) left--;
         end
      end
      if (t >= 600) to_err++;
      bus.ss_dout_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic run(input bit stall_mode);
      u_cnt = 0; v_cnt = 0; d_cnt = 0; addr_err = 0; data_err = 0;
      start_cnt = 0; done_cnt = 0; stab_err = 0; to_err = 0; first_u = '0;
      stream(NW);
      chk("busy_loading", bus.busy, 1);
      core();
      read_ss(stall_mode);
      repeat (3) @(negedge clk);
      chk("u_writes", u_cnt, 139);
      chk("v_writes", v_cnt, 138);
      chk("d_writes", d_cnt, 16);
      chk("addr_seq", addr_err, 0);
      chk("load_data", data_err, 0);
      chk("first_u_word", first_u, 128'h00000004_00000003_00000002_00000001);
      chk("start_pulses", start_cnt, 1);
      chk("done_pulses", done_cnt, 1);
      chk("rx_count", rx_q.size(), 16);
      for (int k = 0; k < 16; k++) chk("ss_word", k < rx_q.size() ? rx_q[k] : 32'hx, rev(mem[k]));
      chk("ss_stable", stab_err, 0);
      chk("stall_hit", stalled, stall_mode);
      chk("cc_final", bus.cycle_count, CC);
      chk("busy_after", bus.busy, 0);
      chk("ready_after", bus.ct_din_ready, 1);
      chk("timeouts", to_err, 0);
   endtask

   initial begin
      bus.ct_din = '0;
      bus.ct_din_valid = 1'b0;
      bus.ss_dout_ready = 1'b1;
      bus.core_done = 1'b0;
      for (int k = 0; k < 16; k++)
         mem[k] = (k == 0) ? 32'h11223344 : {8'(k), 8'(k + 16), 8'(k + 32), 8'(k + 48)};
      repeat (2) @(negedge clk);
      chk("rst_ctl", {bus.ct_din_ready, bus.decap_in_wen, bus.busy, bus.start, bus.done,
                      bus.ss_dout_valid, bus.decap_out_en}, 0);
      chk("rst_addr", {bus.decap_in_type, bus.decap_in_addr, bus.decap_out_addr}, 0);
      chk("rst_decap_in", bus.decap_in, 0);
      chk("rst_ss_dout", bus.ss_dout, 0);
      chk("rst_cc", bus.cycle_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready", bus.ct_din_ready, 1);
      chk("idle_busy", bus.busy, 0);
      run(1'b0);
      run(1'b1);
      stream(300);
      chk("mid_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("arst_ctl", {bus.ct_din_ready, bus.decap_in_wen, bus.busy, bus.start, bus.done,
                       bus.ss_dout_valid, bus.decap_out_en}, 0);
      chk("arst_addr", {bus.decap_in_type, bus.decap_in_addr, bus.decap_out_addr}, 0);
      chk("arst_decap_in", bus.decap_in, 0);
      chk("arst_cc", bus.cycle_count, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run(1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/decap_host_if.md
Name: decap_host_if

Overview:
- Host-side driver for the decap core's load and readout interface.
- Accepts a 32-bit ciphertext stream (u, then v, then d) over valid/ready.
- Packs the stream into RAMWIDTH-bit words and drives decap_in_type, decap_in, decap_in_addr and decap_in_wen, then pulses start.
- After the core's done, reads the 16-word shared secret over decap_out_en/decap_out_addr/decap_out, byte-reverses each word and streams it out over valid/ready.

Parameters:
- parameter_set, "hqc128": selects N ("hqc128" 17669, "hqc192" 35851, "hqc256" 57637).
- RAMWIDTH, 128: core load word width; must be a multiple of 32.
- RAMDEPTH, derived, ceil(N/RAMWIDTH): u word count (139 for hqc128); v word count is RAMDEPTH-1.
- LOG_RAMDEPTH, derived, `CLOG2(RAMDEPTH)`: address width.
- SS_WORDS, 16: shared-secret / d word count (32-bit words).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ct_din  in  32  ciphertext stream word
- ct_din_valid  in  1  host word valid
- ct_din_ready  out  1  block accepts word
- ss_dout  out  32  byte-reversed shared-secret word
- ss_dout_valid  out  1  output word valid
- ss_dout_ready  in  1  host accepts word
- busy  out  1  high from first accepted word until done
- done  out  1  one-cycle pulse after last ss word handshake
- decap_in_type  out  2  3=u, 2=v, 1=d, 0=idle
- decap_in  out  RAMWIDTH  packed load word
- decap_in_addr  out  LOG_RAMDEPTH  load address
- decap_in_wen  out  1  load write strobe
- start  out  1  one-cycle core start pulse
- core_done  in  1  decap core done
- decap_out_en  out  1  ss read enable
- decap_out_addr  out  LOG_RAMDEPTH  ss read address
- decap_out  in  32  ss read data, valid 1 cycle after addr/en
- cycle_count  out  32  see Optional Feature

Behaviour:
- Interface: one clock clk; rst asynchronous active-high.
- Reset: all outputs 0; FSM in IDLE. A reset mid-operation aborts immediately, discards partial packing and issues no further wen/start.
- FSM states: IDLE -> LOAD_U -> LOAD_V -> LOAD_D -> START -> WAIT_DONE -> READ_SS -> IDLE.
- IDLE: ct_din_ready=1; the first handshake enters LOAD_U and is counted as u word 0.
- LOAD_U/LOAD_V packing:
  - Word i of a group (i=0..RAMWIDTH/32-1) goes to bits [32i+31:32i].
  - The cycle after the 4th handshake, the block drives decap_in_wen=1 for exactly one cycle, with decap_in, decap_in_addr and decap_in_type stable in that same cycle.
  - The address increments after each write.
  - ct_din_ready=0 during the write cycle, so at most one write occurs per 5 cycles at full rate.
- Group counts: LOAD_U writes RAMDEPTH words, type 3. LOAD_V writes RAMDEPTH-1 words, type 2. Address resets to 0 at each state change.
- LOAD_D: no packing. Each handshake writes ct_din into decap_in[31:0] (upper bits 0), type 1, the next cycle. Addresses run 0..SS_WORDS-1.
- Backpressure: ct_din_valid low stalls with no state change. ct_din_ready=0 in START, WAIT_DONE and READ_SS.
- START: start=1 for one cycle, then WAIT_DONE.
- WAIT_DONE: waits for core_done=1. core_done is ignored in all other states.
- READ_SS:
  - Drives decap_out_en=1 and decap_out_addr=k. The word captured one cycle later is presented as ss_dout with bytes reversed (ss_dout[7:0]=decap_out[31:24], etc.).
  - One-entry output register: the next read issues only when the register is empty or is being consumed in the same cycle; no word is lost or duplicated under ss_dout_ready stalls.
  - After word SS_WORDS-1 is accepted, done pulses for one cycle, busy falls, and the FSM returns to IDLE.
- ss_dout_valid holds until accepted; ss_dout is stable while valid && !ready.

Optional Feature:
- Macro: DECAP_HOST_CYCLE_CNT_EN.
- When defined: cycle_count clears at the start pulse, increments every cycle in WAIT_DONE, freezes when core_done is seen, and holds until the next start or reset.
- When undefined: cycle_count is tied to 0 and no counter logic exists.

Test Plan:
- hqc128, full-rate stream of 556+552+16 words -> exactly 139 wen with type 3 (addr 0..138), 138 with type 2 (addr 0..137), then 16 with type 1 (addr 0..15); exactly one start pulse.
- u words 0x00000001,0x00000002,0x00000003,0x00000004 -> first write decap_in=0x00000004_00000003_00000002_00000001 at addr 0.
- Core model returns 0x11223344 at addr 0 -> ss_dout=0x44332211; all 16 words in address order; done pulses once.
- ss_dout_ready toggling 1/0 every cycle, plus a 10-cycle stall on word 5 -> 16 distinct words, no drop or duplicate, ss_dout stable while stalled.
- rst asserted after 300 input words -> all outputs 0 immediately; a new full stream afterwards produces a correct run from addr 0.
- With DECAP_HOST_CYCLE_CNT_EN, core_done raised 1000 cycles after start -> cycle_count=1000 (±1 per counting convention, fixed in RTL), held after done; without the macro -> cycle_count=0 throughout.
